// File: rtl/pet_pkg.sv
// Shared definitions for the virtual-pet need engine: FSM states, face codes,
// parameter defaults and a small counter-width helper.
package pet_pkg;

  typedef enum logic [1:0] {
    ST_AWAKE = 2'd0,
    ST_SLEEP = 2'd1,
    ST_DEAD  = 2'd2
  } pet_state_e;

  localparam logic [3:0] MOOD_NEUTRAL  = 4'd0;
  localparam logic [3:0] MOOD_HAPPY    = 4'd1;
  localparam logic [3:0] MOOD_SLEEP    = 4'd2;
  localparam logic [3:0] MOOD_LOW_BASE = 4'd4;
  localparam logic [3:0] MOOD_DEAD     = 4'd15;

  localparam int DEF_N_CH     = 3;
  localparam int DEF_LEVEL_W  = 3;
  localparam int DEF_TICK_DIV = 50_000_000;
  localparam int DEF_DECAY_S  = 10;
  localparam int DEF_REST_S   = 5;
  localparam int DEF_STEP     = 2;
  localparam int DEF_LOW_TH   = 1;
  localparam int DEF_GRACE_S  = 20;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/need_channel.sv
// One need channel: a saturating level register plus its own seconds counter.
// A replenish pulse beats a decay/rest step landing in the same cycle.
module need_channel
  import pet_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int DECAY_S = DEF_DECAY_S,
  parameter int REST_S  = DEF_REST_S,
  parameter int STEP    = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               rest_mode,
  input  logic               inc,
  output logic [LEVEL_W-1:0] level
);

  localparam int SEC_MAX = (DECAY_S > REST_S) ? DECAY_S : REST_S;
  localparam int SEC_W   = cnt_width(SEC_MAX);
  localparam logic [LEVEL_W-1:0] MAX_LVL    = '1;
  localparam logic [SEC_W-1:0]   DECAY_LAST = SEC_W'(DECAY_S - 1);
  localparam logic [SEC_W-1:0]   REST_LAST  = SEC_W'(REST_S - 1);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [SEC_W-1:0]   period_last;
  int                 sum;

  // Arbitrate replenish against the per-second step and compute the next level.
  always_comb begin
    level_d     = level_q;
    sec_d       = sec_q;
    sum         = int'(level_q) + STEP;
    period_last = rest_mode ? REST_LAST : DECAY_LAST;
    if (inc) begin
      level_d = (sum >= int'(MAX_LVL)) ? MAX_LVL : LEVEL_W'(sum);
      sec_d   = '0;
    end else if (tick) begin
      if (sec_q >= period_last) begin
        sec_d = '0;
        if (rest_mode) begin
          level_d = (level_q == MAX_LVL) ? MAX_LVL : level_q + LEVEL_W'(1);
        end else begin
          level_d = (level_q == '0) ? '0 : level_q - LEVEL_W'(1);
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  // Level and seconds counter registers; reset fills the need to the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= MAX_LVL;
      sec_q   <= '0;
    end else begin
      level_q <= level_d;
      sec_q   <= sec_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/pet_need_engine.sv
// Virtual-pet need engine: one-second prescaler, AWAKE/SLEEP/DEAD FSM,
// starvation grace counter and a registered face/status encoder.
module pet_need_engine
  import pet_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int LEVEL_W  = DEF_LEVEL_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DECAY_S  = DEF_DECAY_S,
  parameter int REST_S   = DEF_REST_S,
  parameter int STEP     = DEF_STEP,
  parameter int LOW_TH   = DEF_LOW_TH,
  parameter int GRACE_S  = DEF_GRACE_S
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           inc,
  input  logic                      sleep_req,
  input  logic                      wake_req,
  input  logic                      test_en,
  output logic [N_CH*LEVEL_W-1:0]   level,
  output logic [N_CH-1:0]           low,
  output logic [3:0]                mood,
  output logic                      sleeping,
  output logic                      dead
);

  localparam int FAST_DIV = ((TICK_DIV >> 4) > 0) ? (TICK_DIV >> 4) : 1;
  localparam int PRE_W    = cnt_width(TICK_DIV);
  localparam int GR_W     = cnt_width(GRACE_S + 1);
  localparam logic [PRE_W-1:0]   SLOW_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]   FAST_LAST = PRE_W'(FAST_DIV - 1);
  localparam logic [LEVEL_W-1:0] MAX_LVL   = '1;
  localparam logic [LEVEL_W-1:0] HAPPY_LVL = MAX_LVL - LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LOW_LVL   = LEVEL_W'(LOW_TH);

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic                      test_en_q, test_en_d;
  logic                      sec_tick;
  logic [GR_W-1:0]           grace_q, grace_d;
  logic                      grace_hit;
  int                        zero_cnt;
  pet_state_e                state_q, state_d;
  logic [N_CH*LEVEL_W-1:0]   level_w;
  logic [N_CH-1:0]           inc_gated;
  logic [N_CH-1:0]           rest_vec;
  logic                      chan_tick;
  logic [N_CH-1:0]           low_q, low_d;
  logic [3:0]                mood_q, mood_d;
  logic                      sleeping_q, sleeping_d;
  logic                      dead_q, dead_d;
  int                        low_idx;
  logic                      all_happy;

  // Prescaler: a change of speed mode restarts the count without a tick.
  always_comb begin
    pre_d     = pre_q;
    test_en_d = test_en;
    sec_tick  = 1'b0;
    if (test_en != test_en_q) begin
      pre_d = '0;
    end else if (pre_q >= (test_en ? FAST_LAST : SLOW_LAST)) begin
      pre_d    = '0;
      sec_tick = 1'b1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Channel controls: only energy rests while asleep, nothing moves once dead.
  always_comb begin
    chan_tick   = sec_tick && (state_q != ST_DEAD);
    inc_gated   = (state_q == ST_AWAKE) ? inc : '0;
    rest_vec    = '0;
    rest_vec[0] = (state_q == ST_SLEEP);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    need_channel #(
      .LEVEL_W (LEVEL_W),
      .DECAY_S (DECAY_S),
      .REST_S  (REST_S),
      .STEP    (STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (chan_tick),
      .rest_mode (rest_vec[g]),
      .inc       (inc_gated[g]),
      .level     (level_w[g*LEVEL_W +: LEVEL_W])
    );
  end

  // Grace counter: seconds spent with two or more needs fully drained.
  always_comb begin
    zero_cnt  = 0;
    grace_d   = grace_q;
    grace_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (level_w[i*LEVEL_W +: LEVEL_W] == '0) zero_cnt = zero_cnt + 1;
    end
    if (state_q != ST_DEAD) begin
      if (zero_cnt < 2) begin
        grace_d = '0;
      end else if (sec_tick) begin
        grace_d   = grace_q + GR_W'(1);
        grace_hit = (int'(grace_q) + 1 >= GRACE_S);
      end
    end
  end

  // Next-state logic; wake beats sleep and starvation beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_AWAKE: begin
        if (grace_hit)                     state_d = ST_DEAD;
        else if (sleep_req && !wake_req)   state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (grace_hit)                                          state_d = ST_DEAD;
        else if (wake_req || level_w[LEVEL_W-1:0] == MAX_LVL)   state_d = ST_AWAKE;
      end
      ST_DEAD:  state_d = ST_DEAD;
      default:  state_d = ST_AWAKE;
    endcase
  end

  // Status encoder: face code and flags derived from the current state/levels.
  always_comb begin
    low_d      = '0;
    low_idx    = 0;
    all_happy  = 1'b1;
    mood_d     = MOOD_NEUTRAL;
    sleeping_d = (state_q == ST_SLEEP);
    dead_d     = (state_q == ST_DEAD);
    for (int i = N_CH - 1; i >= 0; i--) begin
      low_d[i] = (level_w[i*LEVEL_W +: LEVEL_W] <= LOW_LVL);
      if (low_d[i]) low_idx = i;
      if (level_w[i*LEVEL_W +: LEVEL_W] < HAPPY_LVL) all_happy = 1'b0;
    end
    if (state_q == ST_DEAD)       mood_d = MOOD_DEAD;
    else if (state_q == ST_SLEEP) mood_d = MOOD_SLEEP;
    else if (|low_d)              mood_d = MOOD_LOW_BASE + 4'(low_idx);
    else if (all_happy)           mood_d = MOOD_HAPPY;
  end

  // All top-level registers; reset discards every in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      test_en_q  <= test_en;
      grace_q    <= '0;
      state_q    <= ST_AWAKE;
      low_q      <= '0;
      mood_q     <= MOOD_HAPPY;
      sleeping_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      test_en_q  <= test_en_d;
      grace_q    <= grace_d;
      state_q    <= state_d;
      low_q      <= low_d;
      mood_q     <= mood_d;
      sleeping_q <= sleeping_d;
      dead_q     <= dead_d;
    end
  end

  assign level    = level_w;
  assign low      = low_q;
  assign mood     = mood_q;
  assign sleeping = sleeping_q;
  assign dead     = dead_q;

endmodule

// File: tb/tb_pet_need_engine.sv
// Scoreboard bench for pet_need_engine with a fast 32-clock second.
module tb_pet_need_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] inc = '0;
   logic       sleep_req = 1'b0;
   logic       wake_req = 1'b0;
   logic       test_en = 1'b0;
   logic [8:0] level;
   logic [2:0] low;
   logic [3:0] mood;
   logic       sleeping;
   logic       dead;

   typedef struct {
      string      name;
      logic [8:0] lvl;
      logic [2:0] low;
      logic [3:0] mood;
      logic       sl;
      logic       dd;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   pet_need_engine #(
      .N_CH(3), .LEVEL_W(3), .TICK_DIV(32), .DECAY_S(2), .REST_S(1),
      .STEP(2), .LOW_TH(1), .GRACE_S(3)
   ) dut (
      .clk(clk), .rst(rst), .inc(inc), .sleep_req(sleep_req), .wake_req(wake_req),
      .test_en(test_en), .level(level), .low(low), .mood(mood),
      .sleeping(sleeping), .dead(dead)
   );

   always #5 clk = ~clk;

   // Monitor: drain every pending expectation at the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checks++;
         if (level !== cur.lvl || low !== cur.low || mood !== cur.mood ||
             sleeping !== cur.sl || dead !== cur.dd) begin
            errors++;
            $display("[TB] FAIL %s: got level=%o low=%b mood=%0d sleeping=%b dead=%b, expected level=%o low=%b mood=%0d sleeping=%b dead=%b",
                     cur.name, level, low, mood, sleeping, dead,
                     cur.lvl, cur.low, cur.mood, cur.sl, cur.dd);
         end
      end
   end

   // Advance the bench to an absolute cycle count after the last reset.
   task automatic stepTo(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Cycle count restarts at the last edge that samples rst high.
   task automatic doReset();
      inc = '0; sleep_req = 1'b0; wake_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   // One-cycle input pulse, sampled at the next rising edge.
   task automatic applyStimulus(input logic [2:0] inc_v, input logic sl, input logic wk);
      inc = inc_v; sleep_req = sl; wake_req = wk;
      @(posedge clk); #1;
      cyc++;
      inc = '0; sleep_req = 1'b0; wake_req = 1'b0;
   endtask

   // Queue an expectation for the monitor to compare at the next falling edge.
   task automatic checkOutput(input string name, input int c2, input int c1, input int c0,
                              input logic [2:0] lo, input int md, input logic sl, input logic dd);
      exp_t e;
      e.name = name;
      e.lvl  = {3'(c2), 3'(c1), 3'(c0)};
      e.low  = lo;
      e.mood = 4'(md);
      e.sl   = sl;
      e.dd   = dd;
      exp_q.push_back(e);
   endtask

   // Directed sequence covering decay, replenish, sleep, death and fast time.
   initial begin
      doReset();
      checks++;
      if (level !== 9'o777 || low !== 3'b000 || mood !== 4'd1 ||
          sleeping !== 1'b0 || dead !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: level=%o low=%b mood=%0d sleeping=%b dead=%b",
                  level, low, mood, sleeping, dead);
      end
      checkOutput("reset", 7, 7, 7, 3'b000, 1, 0, 0);
      stepTo(16);  checkOutput("idle_7", 7, 7, 7, 3'b000, 1, 0, 0);
      stepTo(80);  checkOutput("idle_6_happy", 6, 6, 6, 3'b000, 1, 0, 0);
      stepTo(144); checkOutput("idle_5_neutral", 5, 5, 5, 3'b000, 0, 0, 0);
      stepTo(336); checkOutput("idle_2", 2, 2, 2, 3'b000, 0, 0, 0);
      stepTo(400); checkOutput("idle_1_low", 1, 1, 1, 3'b111, 4, 0, 0);
      stepTo(464); checkOutput("idle_0", 0, 0, 0, 3'b111, 4, 0, 0);
      stepTo(560); checkOutput("idle_dead", 0, 0, 0, 3'b111, 15, 0, 1);

      doReset();
      stepTo(100); applyStimulus(3'b010, 0, 0);
      stepTo(104); checkOutput("inc1_sat", 6, 7, 6, 3'b000, 1, 0, 0);
      stepTo(144); checkOutput("inc1_cnt_clear", 5, 7, 5, 3'b000, 0, 0, 0);
      stepTo(176); checkOutput("inc1_decay_late", 5, 6, 5, 3'b000, 0, 0, 0);
      stepTo(191); applyStimulus(3'b001, 0, 0);
      stepTo(200); checkOutput("inc0_on_tick", 4, 6, 7, 3'b000, 0, 0, 0);
      stepTo(240); checkOutput("after_inc0", 4, 5, 7, 3'b000, 0, 0, 0);
      stepTo(270); checkOutput("after_inc0_b", 3, 5, 6, 3'b000, 0, 0, 0);

      doReset();
      stepTo(260); applyStimulus(3'b000, 1, 0);
      stepTo(270); checkOutput("sleep_enter", 3, 3, 3, 3'b000, 2, 1, 0);
      stepTo(300); checkOutput("sleep_e4", 3, 3, 4, 3'b000, 2, 1, 0);
      stepTo(336); checkOutput("sleep_e5", 2, 2, 5, 3'b000, 2, 1, 0);
      stepTo(400); checkOutput("auto_wake", 1, 1, 7, 3'b110, 5, 0, 0);
      stepTo(404); applyStimulus(3'b000, 1, 1);
      stepTo(410); checkOutput("wake_wins", 1, 1, 7, 3'b110, 5, 0, 0);
      stepTo(460); checkOutput("two_zero", 0, 0, 6, 3'b110, 5, 0, 0);
      stepTo(530); checkOutput("grace_run", 0, 0, 5, 3'b110, 5, 0, 0);
      stepTo(560); checkOutput("dead", 0, 0, 5, 3'b110, 15, 0, 1);
      stepTo(570); applyStimulus(3'b111, 1, 0);
      stepTo(700);
      checks++;
      if (dead !== 1'b1 || mood !== 4'd15 || level !== {3'd0, 3'd0, 3'd5}) begin
         errors++;
         $display("[TB] FAIL dead_wait_expired: level=%o mood=%0d dead=%b",
                  level, mood, dead);
      end
      checkOutput("dead_frozen", 0, 0, 5, 3'b110, 15, 0, 1);
      doReset();
      checkOutput("reset_from_dead", 7, 7, 7, 3'b000, 1, 0, 0);

      test_en = 1'b1;
      stepTo(3);  checkOutput("fast_7", 7, 7, 7, 3'b000, 1, 0, 0);
      stepTo(7);  checkOutput("fast_6", 6, 6, 6, 3'b000, 1, 0, 0);
      stepTo(11); checkOutput("fast_5", 5, 5, 5, 3'b000, 0, 0, 0);
      stepTo(27); checkOutput("fast_1", 1, 1, 1, 3'b111, 4, 0, 0);
      stepTo(28); test_en = 1'b0;
      stepTo(50); checkOutput("slow_restart", 1, 1, 1, 3'b111, 4, 0, 0);
      stepTo(70); checkOutput("slow_step", 0, 0, 0, 3'b111, 4, 0, 0);

      stepTo(cyc + 2);
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
